shift_parity_unit: RTL

Parametrised serial/parallel shift register with a selectable shift direction and a programmable shift-run length. It provides even or odd parity over the held word, serial output, and busy/done status. It replaces the fixed 8-bit start/stop shift-parity register in the serial datapath, and the controller drives it directly with single-cycle command strobes.

---
 rtl/shift_parity_pkg.sv | 12 +
 rtl/parity_gen.sv | 13 +
 rtl/shift_parity_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/shift_parity_pkg.sv
// Shared types and constants for the shift/parity datapath.
package shift_parity_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } sp_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage : shift_parity_pkg

// File: rtl/parity_gen.sv
// Combinational parity over a word: even parity when odd_mode is 0, odd when 1.
// Kept separate so the deserialiser can reuse it.
module parity_gen #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             odd_mode,
    output logic             parity
);

    assign parity = (^data) ^ odd_mode;

endmodule : parity_gen

// File: rtl/shift_parity_unit.sv
// Serial/parallel shift register with a direction select, a programmable run length
// (0 = continuous until stop), even/odd parity over the held word and busy/done status.
module shift_parity_unit
    import shift_parity_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic             dir,
    input  logic             odd_mode,
    input  logic [LEN_W-1:0] shift_len,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out,
    output logic             parity,
    output logic             busy,
    output logic             done
);

    sp_state_t        state;
    sp_state_t        state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_reg_next;
    logic [WIDTH-1:0] shifted;
    logic [LEN_W-1:0] counter;
    logic [LEN_W-1:0] counter_next;
    logic             run_dir;
    logic             run_dir_next;
    logic             continuous;
    logic             continuous_next;
    logic             done_next;
    logic             eff_dir;

    // Next-state logic: command priority is stop > start > load in IDLE; in SHIFT
    // only stop is honoured and every other cycle moves the word one position.
    always_comb begin
        state_next      = state;
        shift_reg_next  = shift_reg;
        counter_next    = counter;
        run_dir_next    = run_dir;
        continuous_next = continuous;
        done_next       = 1'b0;

        if (run_dir == DIR_LEFT) begin
            shifted = {shift_reg[WIDTH-2:0], serial_in};
        end else begin
            shifted = {serial_in, shift_reg[WIDTH-1:1]};
        end

        case (state)
            IDLE: begin
                if (!stop) begin
                    if (start) begin
                        state_next      = SHIFT;
                        run_dir_next    = dir;
                        counter_next    = shift_len;
                        continuous_next = (shift_len == '0);
                    end else if (load) begin
                        shift_reg_next = parallel_in;
                    end
                end
            end
            SHIFT: begin
                if (stop) begin
                    state_next = IDLE;
                end else begin
                    shift_reg_next = shifted;
                    if (!continuous) begin
                        counter_next = counter - LEN_W'(1);
                        if (counter == LEN_W'(1)) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // All run state lives in one register bank; reset clears it immediately, so a
    // reset mid-run drops the run without a done pulse.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            shift_reg  <= '0;
            counter    <= '0;
            run_dir    <= DIR_LEFT;
            continuous <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            shift_reg  <= shift_reg_next;
            counter    <= counter_next;
            run_dir    <= run_dir_next;
            continuous <= continuous_next;
            done       <= done_next;
        end
    end

    // Output decode: the exit bit follows the latched direction during a run and
    // the live dir input while idle, so the controller can preview the next bit.
    always_comb begin
        busy       = (state == SHIFT);
        eff_dir    = busy ? run_dir : dir;
        data_out   = shift_reg;
        serial_out = (eff_dir == DIR_RIGHT) ? shift_reg[0] : shift_reg[WIDTH-1];
    end

    parity_gen #(
        .WIDTH(WIDTH)
    ) u_parity_gen (
        .data    (shift_reg),
        .odd_mode(odd_mode),
        .parity  (parity)
    );

endmodule : shift_parity_unit
